// File: rtl/proc_pkg.sv
// Encodings shared by the multicycle datapath and its control unit:
// ALU functions, operand/write-back selects and the supported opcodes.
package proc_pkg;

  localparam int NUM_REGS  = 32;
  localparam int REG_IDX_W = 5;

  typedef enum logic [2:0] {
    ALU_PASS = 3'b000,
    ALU_ADD  = 3'b001,
    ALU_SUB  = 3'b010,
    ALU_AND  = 3'b011,
    ALU_XOR  = 3'b100
  } alu_funct_e;

  typedef enum logic [1:0] {
    SRCB_REG = 2'b00,
    SRCB_4   = 2'b01,
    SRCB_IMM = 2'b10,
    SRCB_BR  = 2'b11
  } alu_src_b_e;

  typedef enum logic [1:0] {
    M2R_ALUOUT = 2'b00,
    M2R_MDR    = 2'b01,
    M2R_UIMM   = 2'b10,
    M2R_ZERO   = 2'b11
  } mem_to_reg_e;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_SB   = 7'b1100011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

endpackage

// File: rtl/banco_reg_32x64.sv
// 32-entry register file: two combinational read ports, one synchronous write
// port, synchronous clear on reset; x0 is hardwired to zero.
module banco_reg_32x64
  import proc_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [REG_IDX_W-1:0] rs1,
  input  logic [REG_IDX_W-1:0] rs2,
  input  logic [REG_IDX_W-1:0] rd,
  input  logic                 we,
  input  logic [DATA_W-1:0]    wdata,
  output logic [DATA_W-1:0]    rdata1,
  output logic [DATA_W-1:0]    rdata2
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  // NOTE: this array is built from flops, so it can be cleared on reset; a RAM
  // macro could not be, and the reset loop would then have to go.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we && rd != '0) begin
      regs[rd] <= wdata;
    end
  end

  // Reads see pre-edge contents: a same-cycle write is not forwarded.
  assign rdata1 = (rs1 == '0) ? '0 : regs[rs1];
  assign rdata2 = (rs2 == '0) ? '0 : regs[rs2];

endmodule

// File: rtl/datapath_multiciclo.sv
// Multicycle RV64 datapath: PC, IR, A/B, ALUOut, MDR and register file, updated
// each edge from the control unit's strobes; memories are driven combinationally.
module datapath_multiciclo
  import proc_pkg::*;
#(
  parameter int                DATA_W   = 64,
  parameter logic [DATA_W-1:0] PC_RESET = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              PCSrc,
  input  logic [2:0]        ALUFunct,
  input  logic              ALUSrcA,
  input  logic [1:0]        ALUSrcB,
  input  logic              PCWrite,
  input  logic              PCWriteCond,
  input  logic              BranchOp,
  input  logic              LoadRegA,
  input  logic              LoadRegB,
  input  logic              LoadALUOut,
  input  logic              LoadIR,
  input  logic              LoadMDR,
  input  logic              WriteReg,
  input  logic [1:0]        MemToReg,
  input  logic              IMemWrite,
  input  logic              DMemWrite,
  output logic [31:0]       instruction,
  output logic              zero,
  output logic [DATA_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic              imem_we,
  output logic [31:0]       imem_wdata,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              dmem_we,
  output logic [DATA_W-1:0] pc_out,
  output logic [DATA_W-1:0] alu_out
);

  logic [DATA_W-1:0] pc;
  logic [DATA_W-1:0] old_pc;
  logic [31:0]       ir;
  logic [DATA_W-1:0] reg_a;
  logic [DATA_W-1:0] reg_b;
  logic [DATA_W-1:0] alu_out_reg;
  logic [DATA_W-1:0] mdr;

  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] imm_i;
  logic [DATA_W-1:0] imm_s;
  logic [DATA_W-1:0] imm_b;
  logic [DATA_W-1:0] imm_u;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] pc_next;
  logic              pc_en;

  assign imm_i = {{(DATA_W-12){ir[31]}}, ir[31:20]};
  assign imm_s = {{(DATA_W-12){ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b = {{(DATA_W-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_u = {{(DATA_W-32){ir[31]}}, ir[31:12], 12'b0};

  // Branch target in decode uses old_pc: PC has already advanced past the branch.
  always_comb begin
    if (ALUSrcA)                  alu_a = reg_a;
    else if (ALUSrcB == SRCB_BR)  alu_a = old_pc;
    else                          alu_a = pc;
  end

  always_comb begin
    alu_b = reg_b;
    case (ALUSrcB)
      SRCB_REG: alu_b = reg_b;
      SRCB_4:   alu_b = DATA_W'(4);
      SRCB_IMM: alu_b = (ir[6:0] == OP_S) ? imm_s : imm_i;
      SRCB_BR:  alu_b = imm_b;
      default:  alu_b = reg_b;
    endcase
  end

  // NOTE: alu_result gets a value before the case so that the undefined codes
  // and any missed branch cannot leave it unassigned and infer a latch.
  always_comb begin
    alu_result = '0;
    case (ALUFunct)
      ALU_PASS: alu_result = alu_a;
      ALU_ADD:  alu_result = alu_a + alu_b;
      ALU_SUB:  alu_result = alu_a - alu_b;
      ALU_AND:  alu_result = alu_a & alu_b;
      ALU_XOR:  alu_result = alu_a ^ alu_b;
      default:  alu_result = '0;
    endcase
  end

  assign zero = (alu_result == '0);

  always_comb begin
    wdata = '0;
    case (MemToReg)
      M2R_ALUOUT: wdata = alu_out_reg;
      M2R_MDR:    wdata = mdr;
      M2R_UIMM:   wdata = imm_u;
      M2R_ZERO:   wdata = '0;
      default:    wdata = '0;
    endcase
  end

  // BranchOp inverts the zero test: 0 = beq, 1 = bne.
  assign pc_en   = PCWrite | (PCWriteCond & (zero ^ BranchOp));
  assign pc_next = PCSrc ? alu_out_reg : alu_result;

  // NOTE: non-blocking assignments make every enabled register sample the
  // pre-edge values, so simultaneous strobes update in parallel.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= PC_RESET;
      old_pc      <= '0;
      ir          <= '0;
      reg_a       <= '0;
      reg_b       <= '0;
      alu_out_reg <= '0;
      mdr         <= '0;
    end else begin
      if (pc_en)      pc          <= pc_next;
      if (LoadIR) begin
        ir     <= imem_rdata;
        old_pc <= pc;
      end
      if (LoadRegA)   reg_a       <= rs1_data;
      if (LoadRegB)   reg_b       <= rs2_data;
      if (LoadALUOut) alu_out_reg <= alu_result;
      if (LoadMDR)    mdr         <= dmem_rdata;
    end
  end

  banco_reg_32x64 #(
    .DATA_W(DATA_W)
  ) u_banco (
    .clk   (clk),
    .reset (reset),
    .rs1   (ir[19:15]),
    .rs2   (ir[24:20]),
    .rd    (ir[11:7]),
    .we    (WriteReg),
    .wdata (wdata),
    .rdata1(rs1_data),
    .rdata2(rs2_data)
  );

  assign instruction = ir;
  assign imem_addr   = pc;
  assign imem_we     = IMemWrite;
  assign imem_wdata  = reg_b[31:0];
  assign dmem_addr   = alu_out_reg;
  assign dmem_wdata  = reg_b;
  assign dmem_we     = DMemWrite;
  assign pc_out      = pc;
  assign alu_out     = alu_out_reg;

endmodule

// File: tb/tb_datapath_multiciclo.sv
// Scoreboard bench for datapath_multiciclo: directed instruction sequences plus
// random strobes, checked against a behavioural model of the architectural state.
`timescale 1ns/1ps
module tb_datapath_multiciclo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, PCSrc, ALUSrcA, PCWrite, PCWriteCond, BranchOp;
  logic [2:0]  ALUFunct;
  logic [1:0]  ALUSrcB, MemToReg;
  logic        LoadRegA, LoadRegB, LoadALUOut, LoadIR, LoadMDR, WriteReg;
  logic        IMemWrite, DMemWrite;
  logic [31:0] instruction, imem_rdata, imem_wdata;
  logic        zero, imem_we, dmem_we;
  logic [63:0] imem_addr, dmem_addr, dmem_wdata, dmem_rdata, pc_out, alu_out;

  datapath_multiciclo #(.DATA_W(64), .PC_RESET(64'd0)) dut (
    .clk(clk), .reset(reset), .PCSrc(PCSrc), .ALUFunct(ALUFunct), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchOp(BranchOp),
    .LoadRegA(LoadRegA), .LoadRegB(LoadRegB), .LoadALUOut(LoadALUOut), .LoadIR(LoadIR),
    .LoadMDR(LoadMDR), .WriteReg(WriteReg), .MemToReg(MemToReg), .IMemWrite(IMemWrite),
    .DMemWrite(DMemWrite), .instruction(instruction), .zero(zero), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_we(imem_we), .imem_wdata(imem_wdata),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_we(dmem_we), .pc_out(pc_out), .alu_out(alu_out)
  );

  typedef struct packed {
    logic       rst;
    logic       pc_src;
    logic [2:0] funct;
    logic       src_a;
    logic [1:0] src_b;
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_op;
    logic       load_a;
    logic       load_b;
    logic       load_aluout;
    logic       load_ir;
    logic       load_mdr;
    logic       write_reg;
    logic [1:0] mem_to_reg;
    logic       imem_write;
    logic       dmem_write;
  } ctrl_t;

  typedef enum {SIG_PC, SIG_INSTR, SIG_ALUOUT, SIG_IADDR, SIG_DADDR, SIG_DWDATA,
                SIG_IWDATA, SIG_IWE, SIG_DWE, SIG_ZERO} sig_e;
  typedef struct {
    sig_e        sel;
    logic [63:0] want;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Architectural state of the reference model and the bench's data memory.
  logic [63:0] m_pc, m_old_pc, m_a, m_b, m_aluout, m_mdr;
  logic [31:0] m_ir;
  logic [63:0] m_regs [32];
  logic [63:0] dmem [logic [63:0]];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, got, want);
  endtask

  task automatic push(input sig_e s, input logic [63:0] v, input string n);
    exp_t e;
    e.sel = s; e.want = v; e.name = n;
    sb_q.push_back(e);
  endtask

  function automatic logic [63:0] actual(input sig_e s);
    case (s)
      SIG_PC:     return pc_out;
      SIG_INSTR:  return {32'b0, instruction};
      SIG_ALUOUT: return alu_out;
      SIG_IADDR:  return imem_addr;
      SIG_DADDR:  return dmem_addr;
      SIG_DWDATA: return dmem_wdata;
      SIG_IWDATA: return {32'b0, imem_wdata};
      SIG_IWE:    return {63'b0, imem_we};
      SIG_DWE:    return {63'b0, dmem_we};
      default:    return {63'b0, zero};
    endcase
  endfunction

  // Monitor: every expectation queued during a cycle is compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check(e.name, actual(e.sel), e.want);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  function automatic logic [63:0] sx(input logic [63:0] v, input int bits);
    logic [63:0] r;
    r = v << (64 - bits);
    return 64'($signed(r) >>> (64 - bits));
  endfunction

  function automatic logic [63:0] alu(input logic [2:0] f, input logic [63:0] x, input logic [63:0] y);
    case (f)
      3'd0:    return x;
      3'd1:    return x + y;
      3'd2:    return x - y;
      3'd3:    return x & y;
      3'd4:    return x ^ y;
      default: return '0;
    endcase
  endfunction

  function automatic logic [63:0] op_a(input ctrl_t c);
    if (c.src_a) return m_a;
    return (c.src_b == 2'b11) ? m_old_pc : m_pc;
  endfunction

  function automatic logic [63:0] op_b(input ctrl_t c);
    logic [31:0] i;
    i = m_ir;
    case (c.src_b)
      2'd0:    return m_b;
      2'd1:    return 64'd4;
      2'd2:    return (i[6:0] == 7'b0100011) ? sx(64'({i[31:25], i[11:7]}), 12) : sx(64'(i[31:20]), 12);
      default: return sx(64'({i[31], i[7], i[30:25], i[11:8], 1'b0}), 13);
    endcase
  endfunction

  task automatic model_reset();
    m_pc = '0; m_old_pc = '0; m_ir = '0; m_a = '0; m_b = '0; m_aluout = '0; m_mdr = '0;
    for (int k = 0; k < 32; k++) m_regs[k] = '0;
  endtask

  task automatic commit(input ctrl_t c);
    logic [31:0] i;
    logic [63:0] r, wd, rs1v, rs2v;
    logic        take;
    if (c.rst) begin
      model_reset();
      return;
    end
    i    = m_ir;
    r    = alu(c.funct, op_a(c), op_b(c));
    rs1v = m_regs[i[19:15]];
    rs2v = m_regs[i[24:20]];
    case (c.mem_to_reg)
      2'd0:    wd = m_aluout;
      2'd1:    wd = m_mdr;
      2'd2:    wd = sx({32'b0, i[31:12], 12'b0}, 32);
      default: wd = '0;
    endcase
    take = c.pc_write || (c.pc_write_cond && ((r == '0) != c.branch_op));
    if (c.dmem_write) dmem[m_aluout] = m_b;
    if (c.load_mdr) m_mdr = dmem_rdata;
    if (c.load_ir) m_old_pc = m_pc;
    if (take) m_pc = c.pc_src ? m_aluout : r;
    if (c.load_aluout) m_aluout = r;
    if (c.load_a) m_a = rs1v;
    if (c.load_b) m_b = rs2v;
    if (c.write_reg && i[11:7] != 5'd0) m_regs[i[11:7]] = wd;
    if (c.load_ir) m_ir = imem_rdata;
  endtask

  // ---------------- driver ----------------
  task automatic drive(input ctrl_t c, input logic [31:0] iw);
    logic [63:0] r;
    reset = c.rst; PCSrc = c.pc_src; ALUFunct = c.funct; ALUSrcA = c.src_a; ALUSrcB = c.src_b;
    PCWrite = c.pc_write; PCWriteCond = c.pc_write_cond; BranchOp = c.branch_op;
    LoadRegA = c.load_a; LoadRegB = c.load_b; LoadALUOut = c.load_aluout; LoadIR = c.load_ir;
    LoadMDR = c.load_mdr; WriteReg = c.write_reg; MemToReg = c.mem_to_reg;
    IMemWrite = c.imem_write; DMemWrite = c.dmem_write;
    imem_rdata = iw;
    if (!dmem.exists(m_aluout)) dmem[m_aluout] = {$urandom, $urandom};
    dmem_rdata = dmem[m_aluout];
    r = alu(c.funct, op_a(c), op_b(c));
    push(SIG_PC, m_pc, "pc");
    push(SIG_IADDR, m_pc, "imem_addr");
    push(SIG_INSTR, {32'b0, m_ir}, "instruction");
    push(SIG_ALUOUT, m_aluout, "alu_out");
    push(SIG_DADDR, m_aluout, "dmem_addr");
    push(SIG_DWDATA, m_b, "dmem_wdata");
    push(SIG_IWDATA, {32'b0, m_b[31:0]}, "imem_wdata");
    push(SIG_IWE, {63'b0, c.imem_write}, "imem_we");
    push(SIG_DWE, {63'b0, c.dmem_write}, "dmem_we");
    push(SIG_ZERO, {63'b0, r == '0}, "zero");
  endtask

  task automatic tick(input ctrl_t c);
    @(posedge clk);
    commit(c);
    #2;
  endtask

  task automatic step(input ctrl_t c, input logic [31:0] iw);
    drive(c, iw);
    tick(c);
  endtask

  function automatic ctrl_t c_fetch();
    ctrl_t c = '0;
    c.load_ir = 1'b1; c.pc_write = 1'b1; c.src_b = 2'b01; c.funct = 3'd1;
    return c;
  endfunction

  function automatic ctrl_t c_decode();
    ctrl_t c = '0;
    c.load_a = 1'b1; c.load_b = 1'b1; c.load_aluout = 1'b1; c.src_b = 2'b11; c.funct = 3'd1;
    return c;
  endfunction

  function automatic ctrl_t c_exec(input logic [2:0] f, input logic [1:0] sb);
    ctrl_t c = '0;
    c.src_a = 1'b1; c.src_b = sb; c.funct = f; c.load_aluout = 1'b1;
    return c;
  endfunction

  function automatic ctrl_t c_wb(input logic [1:0] m2r);
    ctrl_t c = '0;
    c.write_reg = 1'b1; c.mem_to_reg = m2r;
    return c;
  endfunction

  function automatic ctrl_t c_branch(input logic bne);
    ctrl_t c = '0;
    c.pc_write_cond = 1'b1; c.branch_op = bne; c.src_a = 1'b1; c.funct = 3'd2; c.pc_src = 1'b1;
    return c;
  endfunction

  function automatic ctrl_t c_setpc();
    ctrl_t c = '0;
    c.pc_write = 1'b1; c.src_a = 1'b1; c.funct = 3'd0;
    return c;
  endfunction

  // fetch, decode, one execute step, then a constant check on ALUOut
  task automatic run_alu(input logic [31:0] w, input logic [2:0] f, input logic [1:0] sb,
                         input logic [63:0] want, input string nm);
    step(c_fetch(), w);
    step(c_decode(), $urandom);
    step(c_exec(f, sb), $urandom);
    push(SIG_ALUOUT, want, nm);
  endtask

  task automatic goto_x6();
    step(c_fetch(), 32'h00030033);
    step(c_decode(), $urandom);
    step(c_setpc(), $urandom);
    push(SIG_PC, 64'h20, "setpc_0x20");
  endtask

  initial begin
    ctrl_t c;
    ctrl_t idle;
    logic [31:0] r;
    logic [31:0] iw;
    idle = '0;
    {reset, PCSrc, ALUFunct, ALUSrcA, ALUSrcB, PCWrite, PCWriteCond, BranchOp} = '0;
    {LoadRegA, LoadRegB, LoadALUOut, LoadIR, LoadMDR, WriteReg, MemToReg, IMemWrite, DMemWrite} = '0;
    imem_rdata = '0; dmem_rdata = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    model_reset();

    c = '0; c.rst = 1'b1;
    step(c, 32'h0);
    push(SIG_PC, 64'h0, "reset_pc");
    push(SIG_INSTR, 64'h0, "reset_instr");
    push(SIG_ALUOUT, 64'h0, "reset_aluout");

    // addi x1,x0,100
    step(c_fetch(), 32'h06400093);
    push(SIG_PC, 64'h4, "fetch_pc");
    push(SIG_INSTR, 64'h06400093, "fetch_ir");
    step(c_decode(), $urandom);
    push(SIG_ALUOUT, 64'h860, "decode_uses_old_pc0");
    step(c_exec(3'd1, 2'b10), $urandom);
    push(SIG_ALUOUT, 64'd100, "addi_x1");
    step(c_wb(2'b00), $urandom);

    // addi x2,x0,30 ; addi x0,x0,5
    run_alu(32'h01E00113, 3'd1, 2'b10, 64'd30, "addi_x2");
    step(c_wb(2'b00), $urandom);
    run_alu(32'h00500013, 3'd1, 2'b10, 64'd5, "addi_x0");
    step(c_wb(2'b00), $urandom);
    run_alu(32'h00000233, 3'd0, 2'b00, 64'd0, "x0_stays_zero");

    run_alu(32'h00208233, 3'd1, 2'b00, 64'd130, "add_x1_x2");
    step(c_wb(2'b00), $urandom);
    run_alu(32'h40208233, 3'd2, 2'b00, 64'd70, "sub_x1_x2");
    run_alu(32'h40110233, 3'd2, 2'b00, 64'hFFFF_FFFF_FFFF_FFBA, "sub_x2_x1");

    // sd x1,8(x0) then ld x3,8(x0)
    run_alu(32'h00103423, 3'd1, 2'b10, 64'd8, "sd_addr_s_imm");
    c = '0; c.dmem_write = 1'b1;
    drive(c, $urandom);
    push(SIG_DADDR, 64'd8, "sd_dmem_addr");
    push(SIG_DWDATA, 64'd100, "sd_dmem_wdata");
    push(SIG_DWE, 64'd1, "sd_dmem_we");
    tick(c);
    drive(idle, $urandom);
    push(SIG_DWE, 64'd0, "sd_dmem_we_pulse");
    tick(idle);
    run_alu(32'h00803183, 3'd1, 2'b10, 64'd8, "ld_addr");
    c = '0; c.load_mdr = 1'b1;
    step(c, $urandom);
    step(c_wb(2'b01), $urandom);
    run_alu(32'h00018233, 3'd0, 2'b00, 64'd100, "ld_x3");

    // beq / bne x1,x1,+16 fetched at 0x20
    run_alu(32'h02000313, 3'd1, 2'b10, 64'h20, "addi_x6");
    step(c_wb(2'b00), $urandom);
    goto_x6();
    step(c_fetch(), 32'h00108863);
    push(SIG_PC, 64'h24, "beq_fetch_pc");
    step(c_decode(), $urandom);
    push(SIG_ALUOUT, 64'h30, "beq_target");
    step(c_branch(1'b0), $urandom);
    push(SIG_PC, 64'h30, "beq_taken");
    goto_x6();
    step(c_fetch(), 32'h00108863);
    step(c_decode(), $urandom);
    step(c_branch(1'b1), $urandom);
    push(SIG_PC, 64'h24, "bne_not_taken");

    // lui x5,0x12345, then reset during a second write
    step(c_fetch(), 32'h123452B7);
    step(c_wb(2'b10), $urandom);
    run_alu(32'h00028233, 3'd0, 2'b00, 64'h1234_5000, "lui_x5");
    step(c_fetch(), 32'h123452B7);
    c = c_wb(2'b10); c.rst = 1'b1;
    step(c, $urandom);
    push(SIG_PC, 64'h0, "reset_mid_pc");
    run_alu(32'h00028233, 3'd0, 2'b00, 64'h0, "reset_mid_x5");

    // random strobes and instruction words
    for (int k = 0; k < 400; k++) begin
      r = $urandom;
      c = r[$bits(ctrl_t)-1:0];
      c.rst = ($urandom_range(0, 63) == 0);
      iw = $urandom;
      if ($urandom_range(0, 3) == 0) iw[6:0] = 7'b0100011;
      step(c, iw);
    end

    drive(idle, $urandom);
    tick(idle);
    @(negedge clk);
    #1;
    check("scoreboard_drain", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/datapath_multiciclo.md
Name: datapath_multiciclo

Overview:
- Multicycle RV64 datapath: the responder end of the control-strobe interface driven by the processor control unit.
- Holds PC, old PC, IR, A, B, ALUOut, MDR and a 32x64 register file, plus the ALU and immediate generator.
- Acts on the load, write and mux-select strobes it receives each cycle.
- Returns the instruction word and ALU zero flag to the control unit; drives the external instruction and data memories.

Parameters:
- DATA_W, 64, datapath and register width.
- PC_RESET, 0, PC value after reset.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- PCSrc  in  1  PC source: 0 = ALU result, 1 = ALUOut.
- ALUFunct  in  3  ALU operation select.
- ALUSrcA  in  1  ALU A operand: 0 = PC, 1 = A.
- ALUSrcB  in  2  ALU B operand select.
- PCWrite, PCWriteCond, BranchOp  in  1 each  PC write controls.
- LoadRegA, LoadRegB, LoadALUOut, LoadIR, LoadMDR  in  1 each  register load enables.
- WriteReg  in  1  register-file write enable.
- MemToReg  in  2  register-file write-data select.
- IMemWrite, DMemWrite  in  1 each  memory write strobes.
- instruction  out  32  IR contents, to the control unit.
- zero  out  1  ALU result == 0, combinational.
- imem_addr  out  64  = PC.
- imem_rdata  in  32  instruction memory read data, combinational.
- imem_we  out  1  = IMemWrite.
- imem_wdata  out  32  = B[31:0].
- dmem_addr  out  64  = ALUOut.
- dmem_wdata  out  64  = B.
- dmem_rdata  in  64  data memory read data, combinational.
- dmem_we  out  1  = DMemWrite.
- pc_out, alu_out  out  64 each  debug observation of PC and ALUOut.

Behaviour:
- Clocking: one clock `clk`; reset `reset` is synchronous, active-high and has priority over every strobe.
- Reset values: PC = PC_RESET; old_pc, IR, A, B, ALUOut, MDR and all 32 registers = 0. So instruction = 0, dmem_we = 0, imem_we = 0 (strobe pass-through; the control unit must be in reset too).
- IR and old_pc: on LoadIR, IR <= imem_rdata and old_pc <= PC, in the same edge as the PC update. instruction = IR.
- Register-file reads: combinational from IR[19:15] and IR[24:20]. LoadRegA / LoadRegB capture them into A / B.
- Write/read collision: a WriteReg to the same register in the same edge is not forwarded; A/B capture the old value.
- Register-file write: on WriteReg, reg[IR[11:7]] <= wdata. Writes to x0 are discarded; x0 always reads 0.
- MemToReg: 00 = ALUOut, 01 = MDR, 10 = U-immediate {sext(IR[31:12]), 12'b0}, 11 = 0.
- ALU A mux: ALUSrcA = 1 selects A. ALUSrcA = 0 selects PC, except when ALUSrcB = 11, where it selects old_pc. This makes the branch target in decode relative to the fetched instruction.
- ALU B mux:
  - 00 = B.
  - 01 = 4.
  - 10 = I-immediate, or S-immediate when IR[6:0] = 0100011.
  - 11 = SB-immediate, sign-extended with bit0 = 0.
- ALUFunct: 000 = pass A, 001 = A+B, 010 = A−B, 011 = A&B, 100 = A^B, 101–111 = 0. Add/sub are modulo 2^64 with wrap and no overflow flag.
- ALUOut: loads the ALU result on LoadALUOut.
- MDR: loads dmem_rdata on LoadMDR. The address is the ALUOut value held at that edge.
- PC update: PC <= (PCSrc ? ALUOut : ALU result) when PCWrite, or when PCWriteCond and (zero XOR BranchOp). BranchOp = 0 gives beq, 1 gives bne. PCWrite alone is unconditional.
- Latency:
  - Every register updates exactly one edge after its strobe is sampled high.
  - Memory outputs are purely combinational from current registers.
  - The datapath adds no state, handshake or wait cycles.
- Simultaneous strobes: all enabled registers update in parallel from pre-edge values.
- Reset mid-instruction: all registers return to reset values on that edge; no partial write survives.

Decomposition:
- Shared package `proc_pkg`:
  - ALUFunct codes (ALU_PASS, ALU_ADD, ALU_SUB, ALU_AND, ALU_XOR).
  - ALUSrcB codes (SRCB_REG, SRCB_4, SRCB_IMM, SRCB_BR).
  - MemToReg codes.
  - Opcode constants (R, S, SB, ADDI, LD, LUI), used by both this block and the control unit.
- One natural sub-module: `banco_reg_32x64`, holding the register file with two combinational read ports, one synchronous write port and reset clear.
- The ALU and immediate generator stay inline.

Test Plan:
- Fetch:
  - Stimulus: reset, then LoadIR = 1, PCWrite = 1, ALUSrcB = 01, ALUFunct = 001, imem_rdata = 0x06400093 (addi x1,x0,100).
  - Response: next cycle PC = 4, old_pc = 0, instruction = 0x06400093.
- addi then write:
  - Stimulus: the addi sequence (decode, cal_offset, write).
  - Response: x1 = 100; a further write to rd = 0 leaves x0 = 0.
- add / sub:
  - Stimulus: x1 = 100, x2 = 30.
  - Response: add gives 130; sub gives 70; sub of x2 − x1 gives 0xFFFF_FFFF_FFFF_FFBA.
- sd / ld:
  - Stimulus: sd x1,8(x0), then ld x3,8(x0).
  - Response: dmem_addr = 8, dmem_wdata = 100, dmem_we pulse of 1 cycle; then MDR = 100 and x3 = 100.
- Branch:
  - Stimulus: beq x1,x1,+16 fetched at PC = 0x20.
  - Response: decode ALUOut = 0x30, beq cycle PC = 0x30.
  - Same with BranchOp = 1 (bne): PC stays 0x24.
- lui and reset:
  - Stimulus: lui x5,0x12345.
  - Response: x5 = 0x12345000.
  - Stimulus: assert reset during the write cycle.
  - Response: x5 = 0, PC = 0.
